mdu: RTL

Multiply/divide unit for the EX stage of the pipelined CPU. It consumes the same `srcA`/`srcB` operands as the ALU, runs MULT/MULTU/DIV/DIVU as multi-cycle operations into private HI/LO registers, and supplies MFHI/MFLO data to the EX result mux alongside `aluRes`. It raises a stall request so the hazard unit holds dependent instructions in ID while an operation is in flight.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_counter.sv | 45 ++++
 rtl/mdu.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   md_op_e  : MDU operation encodings carried on mdOp.
//   state_e  : control FSM states.
//   Default latencies and the counter width used by mdu and mdu_counter.
// -----------------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/mdu_counter.sv
// -----------------------------------------------------------------------------
// mdu_counter -- loadable down-counter that times an MDU operation.
// Ports:
//   clk     in   rising-edge clock
//   rstN    in   asynchronous active-low reset
//   load    in   load loadVal on the next edge (has priority over counting)
//   loadVal in   CNT_W-bit value to load
//   en      in   decrement on each edge while the count is non-zero
//   done    out  combinational: high during the cycle whose edge takes 1 -> 0
// -----------------------------------------------------------------------------
module mdu_counter
  import mdu_pkg::*;
(
  input  logic             clk,
  input  logic             rstN,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = loadVal;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The owner acts on the edge that ends this cycle, so done is not registered.
  assign done = en && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- EX-stage multiply/divide unit with private HI/LO registers.
// MULT/MULTU (and DIV/DIVU when built with MDU_DIV_EN) compute their result
// at acceptance into pendHi/pendLo, then hold busy for a fixed latency and
// commit to HI/LO on the last busy edge. MTHI/MTLO write in one cycle;
// MFHI/MFLO are combinational reads of the committed HI/LO.
// Build option: define MDU_DIV_EN to implement DIV/DIVU; otherwise they are
// no-ops and no divider is built.
// Ports:
//   clk       in   rising-edge clock
//   rstN      in   asynchronous active-low reset
//   start     in   valid MDU instruction in EX
//   mdOp      in   [2:0] operation (see mdu_pkg::md_op_e)
//   srcA      in   [31:0] rs operand
//   srcB      in   [31:0] rt operand
//   busy      out  multi-cycle operation in flight
//   stallReq  out  busy, or a multi-cycle op being presented now
//   mdRes     out  [31:0] HI for MFHI, LO for MFLO, else 0
// -----------------------------------------------------------------------------
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        stallReq,
  output logic [31:0] mdRes
);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pendHi_q, pendHi_d;
  logic [31:0] pendLo_q, pendLo_d;
  logic        pendWe_q, pendWe_d;   // cleared for divide-by-zero
  logic        cntLoad;
  logic [CNT_W-1:0] cntVal;
  logic        cntDone;
  logic        isMul;
  logic        isDiv;

  // Sign-extending both operands makes the low 64 bits of one unsigned
  // multiply correct for both MULT and MULTU.
  logic        mulSigned;
  logic [63:0] mulA, mulB, prod;

  assign isMul     = (mdOp == OP_MULT) || (mdOp == OP_MULTU);
  assign mulSigned = (mdOp == OP_MULT);
  assign mulA      = {{32{mulSigned & srcA[31]}}, srcA};
  assign mulB      = {{32{mulSigned & srcB[31]}}, srcB};
  assign prod      = mulA * mulB;

`ifdef MDU_DIV_EN
  // Signed divide runs on magnitudes and restores signs afterwards:
  // quotient truncates toward zero, remainder follows the dividend.
  logic        divSigned, negA, negB;
  logic [31:0] absA, absB, uq, ur, quot, rem;

  assign isDiv     = (mdOp == OP_DIV) || (mdOp == OP_DIVU);
  assign divSigned = (mdOp == OP_DIV);
  assign negA      = divSigned & srcA[31];
  assign negB      = divSigned & srcB[31];
  assign absA      = negA ? (~srcA + 32'd1) : srcA;
  // A zero divisor is replaced so the divider never sees 0; the result is
  // discarded through pendWe anyway.
  assign absB      = (srcB == 32'd0) ? 32'd1 : (negB ? (~srcB + 32'd1) : srcB);
  assign uq        = absA / absB;
  assign ur        = absA % absB;
  assign quot      = (negA ^ negB) ? (~uq + 32'd1) : uq;
  assign rem       = negA ? (~ur + 32'd1) : ur;
`else
  assign isDiv     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    pendHi_d = pendHi_q;
    pendLo_d = pendLo_q;
    pendWe_d = pendWe_q;
    cntLoad  = 1'b0;
    cntVal   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (isMul) begin
            pendHi_d = prod[63:32];
            pendLo_d = prod[31:0];
            pendWe_d = 1'b1;
            cntLoad  = 1'b1;
            cntVal   = CNT_W'(MULT_CYCLES);
            state_d  = S_RUN;
`ifdef MDU_DIV_EN
          end else if (isDiv) begin
            pendHi_d = rem;
            pendLo_d = quot;
            pendWe_d = (srcB != 32'd0);
            cntLoad  = 1'b1;
            cntVal   = CNT_W'(DIV_CYCLES);
            state_d  = S_RUN;
`endif
          end else if (mdOp == OP_MTHI) begin
            hi_d = srcA;
          end else if (mdOp == OP_MTLO) begin
            lo_d = srcA;
          end
        end
      end
      S_RUN: begin
        // Any start presented here is dropped; only the counter matters.
        if (cntDone) begin
          if (pendWe_q) begin
            hi_d = pendHi_q;
            lo_d = pendLo_q;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      pendHi_q <= '0;
      pendLo_q <= '0;
      pendWe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pendHi_q <= pendHi_d;
      pendLo_q <= pendLo_d;
      pendWe_q <= pendWe_d;
    end
  end

  mdu_counter u_counter (
    .clk     (clk),
    .rstN    (rstN),
    .load    (cntLoad),
    .loadVal (cntVal),
    .en      (state_q == S_RUN),
    .done    (cntDone)
  );

  assign busy     = (state_q == S_RUN);
  assign stallReq = busy | (start & (isMul | isDiv));

  always_comb begin
    mdRes = '0;
    if (mdOp == OP_MFHI) begin
      mdRes = hi_q;
    end else if (mdOp == OP_MFLO) begin
      mdRes = lo_q;
    end
  end

endmodule
